alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequences 8/16-bit operations through an external combinational 8-bit ALU; rsp_valid rises 1 (narrow) or 2 (wide) cycles after accept.
// Accepts a request only in IDLE; the response holds stable until rsp_ready, and req_valid is ignored while busy.
module alu_seq #(
    parameter logic [3:0] F_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic [15:0] req_lhs,
    input  logic [15:0] req_rhs,
    output logic [7:0]  alu_lhs,
    output logic [7:0]  alu_rhs,
    output logic [3:0]  alu_op,
    output logic        alu_zf,
    output logic        alu_nf,
    output logic        alu_hf,
    output logic        alu_cf,
    input  logic [7:0]  alu_r,
    input  logic        alu_zf_r,
    input  logic        alu_nf_r,
    input  logic        alu_hf_r,
    input  logic        alu_cf_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  flags,
    input  logic        f_we,
    input  logic [3:0]  f_wdata
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic        wide_q;
    logic [15:0] lhs_q;
    logic [15:0] rhs_q;
    logic [15:0] res;
    logic [3:0]  temp;
    logic [3:0]  alu_flags_r;

    assign alu_flags_r = {alu_zf_r, alu_nf_r, alu_hf_r, alu_cf_r};
    assign req_ready   = (state == IDLE);
    assign rsp_data    = res;

    // Drive the downstream ALU only while an operand byte is in flight
    always_comb begin
        alu_lhs = 8'h00;
        alu_rhs = 8'h00;
        alu_op  = 4'b0000;
        {alu_zf, alu_nf, alu_hf, alu_cf} = 4'b0000;
        case (state)
            LO: begin
                alu_lhs = lhs_q[7:0];
                alu_rhs = rhs_q[7:0];
                alu_op  = op_q;
                {alu_zf, alu_nf, alu_hf, alu_cf} = flags;
            end
            HI: begin
                alu_lhs = lhs_q[15:8];
                alu_rhs = rhs_q[15:8];
                alu_op  = op_q | 4'b0001;
                {alu_zf, alu_nf, alu_hf, alu_cf} = temp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 4'b0000;
            wide_q    <= 1'b0;
            lhs_q     <= 16'h0000;
            rhs_q     <= 16'h0000;
            res       <= 16'h0000;
            temp      <= 4'b0000;
            flags     <= F_RESET;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        // Only ADD/SUB have a carry-chained high-byte form
                        wide_q <= req_wide && (req_op == 4'b0000 || req_op == 4'b0010);
                        lhs_q  <= req_lhs;
                        rhs_q  <= req_rhs;
                        state  <= LO;
                    end
                end
                LO: begin
                    res[7:0] <= alu_r;
                    temp     <= alu_flags_r;
                    if (wide_q) begin
                        state <= HI;
                    end else begin
                        res[15:8] <= 8'h00;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                HI: begin
                    res[15:8] <= alu_r;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An operation's own flag result takes priority over a direct write
            if (state == LO && !wide_q)
                flags <= alu_flags_r;
            else if (state == HI)
                flags <= {temp[3] & alu_zf_r, alu_nf_r, alu_hf_r, alu_cf_r};
            else if (f_we)
                flags <= f_wdata;
        end
    end
endmodule
